// File: rtl/irq_dispatch_if.sv
// Signal bundle between the interrupt queue controller / core (master side)
// and the irq_dispatch responder (slave side).
interface irq_dispatch_if #(
    parameter int ADDR_W = 15
);
    logic              irq1;
    logic              irq2;
    logic              irq3;
    logic              eirq;
    logic [ADDR_W-1:0] pc;
    logic              boundary;
    logic              ien;
    logic              reti;
    logic              mask_we;
    logic [6:0]        mask_wdata;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_addr;
    logic              active;
    logic [2:0]        cur_irq;
    logic              err;

    modport master (
        output irq1, irq2, irq3, pc, boundary, ien, reti, mask_we, mask_wdata,
        input  eirq, jump, jump_addr, ret_valid, ret_addr, active, cur_irq, err
    );

    modport slave (
        input  irq1, irq2, irq3, pc, boundary, ien, reti, mask_we, mask_wdata,
        output eirq, jump, jump_addr, ret_valid, ret_addr, active, cur_irq, err
    );
endinterface

// File: rtl/irq_dispatch.sv
// Interrupt code receiver: pending/mask bitmap, vector redirect with priority
// nesting, and a return-PC / priority stack unwound on reti.
module irq_dispatch #(
    parameter int                ADDR_W    = 15,
    parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(16'h0010),
    parameter int                VEC_SHIFT = 2,
    parameter int                DEPTH     = 4,
    parameter logic [6:0]        MASK_RST  = 7'h7F
) (
    input logic           clk,
    input logic           rst,
    irq_dispatch_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_JUMP, S_ACTIVE} state_t;

    state_t            state, state_nx;
    logic [2:0]        code, best, cur;
    logic [6:0]        mask, pending, set_bits, clr_bits;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [ADDR_W-1:0] stk_pc   [DEPTH];
    logic [2:0]        stk_code [DEPTH];
    logic [ADDR_W-1:0] vec_q, ret_q;
    logic              eirq_q, ret_valid_q, err_q;
    logic              stack_empty, stack_full, dispatch, do_ret;

    assign code        = {bus.irq3, bus.irq2, bus.irq1};
    assign stack_empty = (count == '0);
    assign stack_full  = (count == CNT_W'(DEPTH));
    assign push_idx    = IDX_W'(count);
    assign top_idx     = IDX_W'(count - CNT_W'(1));

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and default every output first, so no latch is inferred.
        best     = '0;
        set_bits = '0;
        for (int k = 1; k <= 7; k++) begin
            if (pending[k-1] && mask[k-1]) best = 3'(k);
            set_bits[k-1] = (code == 3'(k));
        end
    end

    // A masked request stays in pending; only eligibility is gated by the mask.
    assign dispatch = (state != S_JUMP) && bus.boundary && bus.ien && (best > cur)
                      && !stack_full && !bus.reti;
    assign do_ret   = bus.reti && !stack_empty;

    always_comb begin
        clr_bits = '0;
        for (int k = 1; k <= 7; k++) clr_bits[k-1] = dispatch && (best == 3'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (do_ret)              state_nx = (count == CNT_W'(1)) ? S_IDLE : S_ACTIVE;
        else if (dispatch)       state_nx = S_JUMP;
        else if (state == S_JUMP) state_nx = S_ACTIVE;
    end

    always_comb begin
        bus.jump      = (state == S_JUMP);
        bus.jump_addr = (state == S_JUMP) ? vec_q : '0;
        bus.ret_valid = ret_valid_q;
        bus.ret_addr  = ret_valid_q ? ret_q : '0;
        bus.eirq      = eirq_q;
        bus.active    = !stack_empty;
        bus.cur_irq   = cur;
        bus.err       = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= MASK_RST;
            pending     <= '0;
            cur         <= '0;
            count       <= '0;
            vec_q       <= '0;
            ret_q       <= '0;
            eirq_q      <= 1'b0;
            ret_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
            eirq_q      <= (code != 3'd0);
            ret_valid_q <= do_ret;
            pending     <= (pending & ~clr_bits) | set_bits;
            if (bus.mask_we) mask <= bus.mask_wdata;
            if (dispatch) begin
                cur   <= best;
                count <= count + CNT_W'(1);
                vec_q <= VEC_BASE + (ADDR_W'(best) << VEC_SHIFT);
            end else if (do_ret) begin
                cur   <= stk_code[top_idx];
                count <= count - CNT_W'(1);
                ret_q <= stk_pc[top_idx];
            end else if (bus.reti) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: stack storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (dispatch) begin
            stk_pc[push_idx]   <= bus.pc;
            stk_code[push_idx] <= cur;
        end
    end
endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: a queue-based reference model predicts
// eirq / jump / return events and status; a monitor compares every cycle.
module tb_irq_dispatch;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 4;

    logic clk = 1'b1;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_dispatch_if #(.ADDR_W(ADDR_W)) bus();

    irq_dispatch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {int cyc; logic [ADDR_W-1:0] addr;} ev_t;
    typedef struct {int cyc; bit act; int cur; bit err;} status_t;
    typedef struct {logic [ADDR_W-1:0] pc; int prev;} frame_t;

    ev_t     exp_jump[$];
    ev_t     exp_ret[$];
    int      exp_eirq[$];
    status_t exp_st[$];

    // Reference model state
    frame_t     m_stk[$];
    bit         m_pend[1:7];
    bit [6:0]   m_mask;
    int         m_cur;
    bit         m_jumping;
    bit         m_err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    bit run = 1'b1;
    logic [ADDR_W-1:0] tpc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic model_step(input logic r, input logic [2:0] c, input logic [ADDR_W-1:0] p,
                              input logic b, input logic e, input logic rt,
                              input logic mwe, input logic [6:0] md);
        int     nxt;
        int     best;
        bit     disp;
        frame_t f;
        nxt = cyc + 1;
        if (r) begin
            foreach (m_pend[k]) m_pend[k] = 1'b0;
            m_stk.delete();
            m_cur = 0; m_err = 1'b0; m_jumping = 1'b0; m_mask = 7'h7F;
        end else begin
            best = 0;
            for (int k = 1; k <= 7; k++) if (m_pend[k] && m_mask[k-1]) best = k;
            disp = !m_jumping && b && e && (best > m_cur) && (m_stk.size() < DEPTH) && !rt;
            if (rt && m_stk.size() == 0) m_err = 1'b1;
            if (disp) begin
                m_pend[best] = 1'b0;
                m_stk.push_back('{p, m_cur});
                m_cur = best;
                exp_jump.push_back('{nxt, ADDR_W'(32'h10 + 4 * best)});
            end
            if (rt && m_stk.size() > 0) begin
                f = m_stk.pop_back();
                m_cur = f.prev;
                exp_ret.push_back('{nxt, f.pc});
            end
            if (c != 3'd0) begin
                m_pend[c] = 1'b1;
                exp_eirq.push_back(nxt);
            end
            if (mwe) m_mask = md;
            m_jumping = disp;
        end
        exp_st.push_back('{nxt, m_stk.size() > 0, m_cur, m_err});
    endtask

    task automatic drive(input logic r, input logic [2:0] c, input logic [ADDR_W-1:0] p,
                         input logic b, input logic e, input logic rt,
                         input logic mwe, input logic [6:0] md);
        @(negedge clk);
        rst = r;
        {bus.irq3, bus.irq2, bus.irq1} = c;
        bus.pc = p; bus.boundary = b; bus.ien = e; bus.reti = rt;
        bus.mask_we = mwe; bus.mask_wdata = md;
        model_step(r, c, p, b, e, rt, mwe, md);
    endtask

    task automatic step(input logic [2:0] c, input logic rt = 1'b0,
                        input logic mwe = 1'b0, input logic [6:0] md = 7'h7F);
        drive(1'b0, c, tpc, 1'b1, 1'b1, rt, mwe, md);
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'd0);
    endtask

    task automatic monitor_cycle();
        status_t st;
        ev_t     ev;
        bit      exp_e, exp_j, exp_r;
        if (exp_st.size() == 0) begin
            check("status_expected", 32'd0, 32'd1);
        end else begin
            st = exp_st.pop_front();
            check("active", bus.active, st.act);
            check("cur_irq", bus.cur_irq, st.cur);
            check("err", bus.err, st.err);
        end
        exp_e = (exp_eirq.size() > 0) && (exp_eirq[0] == cyc);
        if (exp_e) void'(exp_eirq.pop_front());
        check("eirq", bus.eirq, exp_e);
        exp_j = (exp_jump.size() > 0) && (exp_jump[0].cyc == cyc);
        check("jump", bus.jump, exp_j);
        if (exp_j) begin
            ev = exp_jump.pop_front();
            check("jump_addr", bus.jump_addr, ev.addr);
        end
        exp_r = (exp_ret.size() > 0) && (exp_ret[0].cyc == cyc);
        check("ret_valid", bus.ret_valid, exp_r);
        if (exp_r) begin
            ev = exp_ret.pop_front();
            check("ret_addr", bus.ret_addr, ev.addr);
        end
        check("jump_ret_exclusive", bus.jump & bus.ret_valid, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (run) monitor_cycle();
        end
    end

    initial begin
        logic [2:0] c;
        logic       rt;
        {bus.irq3, bus.irq2, bus.irq1} = 3'd0;
        bus.pc = '0; bus.boundary = 1'b0; bus.ien = 1'b0; bus.reti = 1'b0;
        bus.mask_we = 1'b0; bus.mask_wdata = 7'h7F;
        tpc = '0;

        repeat (2) drive(1'b1, 3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h7F);

        // Single dispatch, then nesting and unwinding
        tpc = 15'h0123; step(3'd3); idle(3);
        tpc = 15'h0200; step(3'd5); idle(3);
        step(3'd0, 1'b1); idle(2); step(3'd0, 1'b1); idle(2);

        // Lower priority held until the running handler returns
        step(3'd5); idle(2); step(3'd2); idle(2);
        step(3'd0, 1'b1); idle(3); step(3'd0, 1'b1); idle(2);

        // Masked request held, released by a mask write
        step(3'd0, 1'b0, 1'b1, 7'h7B); step(3'd3); idle(3);
        step(3'd0, 1'b0, 1'b1, 7'h7F); idle(3); step(3'd0, 1'b1); idle(2);

        // Global enable low holds the request
        drive(1'b0, 3'd4, tpc, 1'b1, 1'b0, 1'b0, 1'b0, 7'h7F);
        repeat (3) drive(1'b0, 3'd0, tpc, 1'b1, 1'b0, 1'b0, 1'b0, 7'h7F);
        idle(3); step(3'd0, 1'b1); idle(2);

        // Full stack blocks a higher request until a pop; final reti underflows
        for (int k = 1; k <= 5; k++) begin
            tpc = 15'(16'h0300 + k);
            step(3'(k)); idle(2);
        end
        idle(2); step(3'd0, 1'b1); idle(3);
        repeat (5) begin step(3'd0, 1'b1); idle(1); end

        // Reset in the middle of a handler
        step(3'd6); idle(2);
        drive(1'b1, 3'd0, tpc, 1'b1, 1'b1, 1'b0, 1'b0, 7'h7F);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            c  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rt = (m_stk.size() > 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 399) == 0, c, 15'($urandom_range(0, 32767)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) < 17, rt,
                  $urandom_range(0, 39) == 0,
                  ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h7F);
        end
        idle(5);

        @(posedge clk);
        #2;
        run = 1'b0;
        check("queues_drained", 32'(exp_jump.size() + exp_ret.size() + exp_eirq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
